lsu_pipelined: RTL
==================

Name: lsu_pipelined

Overview:
- Parametrised load/store unit for the RV64 pipelined core's MEM stage. Takes one load or store request from EX/MEM.
- Generates an aligned data-memory access with byte mask and lane-shifted write data. Waits for a memory acknowledge with timeout.
- Returns sign- or zero-extended load data plus a completion/error response to the writeback stage.
- Replaces the single-cycle, 64-bit-only combinational memory path with a multi-cycle, width-generic handshake unit.

Parameters:
- XLEN, 64, datapath width in bits; 32 or 64 only; bus width is XLEN, XLEN/8 byte lanes.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 15, max cycles to wait for mem_ack before an error response; 0 disables timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  effective byte address (rs1+imm)
- req_wdata  in  XLEN  store data, LSB-aligned (rs2)
- req_rd  in  5  destination register index, passed through
- mem_req  out  1  memory access request, held until ack
- mem_wr_en  out  1  write strobe, valid while mem_req
- mem_addr  out  ADDR_W  XLEN/8-aligned word address
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  XLEN/8  byte-enable mask; 0 for loads
- mem_ack  in  1  memory completed access; rdata valid same cycle
- mem_rdata  in  XLEN  read word
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts response
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors
- resp_rd  out  5  copy of req_rd
- resp_err  out  1  misaligned, illegal funct3, or timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; counter=0. Outputs all 0 except req_ready=1. mem_req drops immediately; an in-flight access is abandoned and no response is issued.
- FSM states: IDLE, ACCESS, RESP.
- req_ready = (state==IDLE). Accept on req_valid & req_ready; register store, funct3, addr, wdata, rd.
- Sizes: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- Illegal funct3 (go to RESP with resp_err=1, no memory access):
  - Stores: funct3 >= 100.
  - Loads: funct3 = 111.
  - XLEN=32 only: D and WU.
- Misaligned (same error handling): addr not a multiple of the access size.
- Legal request: IDLE->ACCESS. Next cycle mem_req=1 and mem_addr = addr with low log2(XLEN/8) bits cleared.
- Byte offset off = addr[log2(XLEN/8)-1:0].
- mem_wmask = ((1<<size_bytes)-1) << off; mem_wdata = req_wdata << (8*off). Both 0 for loads.
- ACCESS: counter increments each cycle mem_ack=0.
  - mem_ack=1: capture data, go to RESP.
  - counter == TIMEOUT-1 with no ack: go to RESP with err.
  - ack and timeout in the same cycle: ack wins, no error.
  - mem_req deasserts in the cycle after ack or timeout.
- Load extension: shifted = mem_rdata >> (8*off). Signed sizes sign-extend from bit 8*size-1; U sizes zero-extend.
- RESP: resp_valid=1 and outputs held stable until resp_ready=1, then go to IDLE. Stores also respond, with resp_rdata=0.
- Latency, no error: accept at cycle T, mem_req at T+1, ack at cycle A>=T+1, resp_valid at A+1. Throughput is one op at a time.
- Latency, error: resp_valid at T+1, mem_req never asserted.
- Timeout: resp_err=1, resp_rdata=0.
- A new request is accepted in the cycle after the response handshake (req_ready high again in IDLE).
- mem_ack while not in ACCESS is ignored.

Test Plan:
- XLEN=64, LD addr=0x100, ack after 2 wait cycles, rdata=0x8877665544332211 -> mem_addr=0x100, wmask=0x00, resp_valid 4 cycles after accept, resp_rdata=0x8877665544332211, err=0.
- LB addr=0x103, rdata=0x00000000_F0000000, then LBU same -> LB resp_rdata=0xFFFFFFFFFFFFFFF0; LBU resp_rdata=0x00000000000000F0.
- SH addr=0x10A, wdata=0xABCD -> mem_addr=0x108, wmask=0x0C, wdata bits[31:16]=0xABCD, mem_wr_en=1; resp_rdata=0, err=0.
- LW addr=0x102 -> no mem_req, resp_valid next cycle, resp_err=1. Also store funct3=100 -> resp_err=1.
- TIMEOUT=15, LD with mem_ack held 0 -> mem_req high exactly 15 cycles, then resp_err=1, resp_rdata=0. Ack on cycle 15 -> err=0 (ack wins).
- Backpressure and reset:
  - resp_ready=0 for 5 cycles -> resp_valid and data held stable and req_ready=0.
  - rst pulse during ACCESS -> mem_req=0 immediately, no response, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_pipelined.sv
// MEM-stage load/store unit: one request at a time, aligned bus access with byte
// mask, ack/timeout wait, then an extended load result or error to writeback.
module lsu_pipelined #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [4:0]          resp_rd,
  output logic                resp_err,
  output logic                busy
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [OFFW-1:0]     off;
  logic [3:0]          sbytes;
  logic [NB-1:0]       wmask_c;
  logic [XLEN-1:0]     shifted, ext;
  logic [1:0]          rsz;
  logic                bad_f3, misalign;

  assign off     = addr_q[OFFW-1:0];
  assign sbytes  = 4'd1 << f3_q[1:0];
  assign shifted = mem_rdata >> {off, 3'b000};

  // Illegal/misaligned requests are decided from the request itself so they
  // skip the bus entirely.
  assign rsz      = req_funct3[1:0];
  assign bad_f3   = (req_store && req_funct3[2]) || (!req_store && req_funct3 == 3'b111) ||
                    (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
  assign misalign = (rsz == 2'd1 && req_addr[0]) || (rsz == 2'd2 && |req_addr[1:0]) ||
                    (rsz == 2'd3 && |req_addr[2:0]);

  always_comb begin
    int nbits;
    logic sbit;
    wmask_c = '0;
    for (int i = 0; i < NB; i++)
      wmask_c[i] = (i >= int'(off)) && (i < int'(off) + int'(sbytes));
    nbits = 8 * int'(sbytes);
    if (nbits > XLEN) nbits = XLEN;
    sbit = shifted[nbits-1] & ~f3_q[2];
    ext  = '0;
    for (int i = 0; i < XLEN; i++)
      ext[i] = (i < nbits) ? shifted[i] : sbit;
  end

  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        store_d = req_store;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rd_d    = req_rd;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = bad_f3 || misalign;
        state_d = (bad_f3 || misalign) ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_wr_en = store_q;
        mem_addr  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        mem_wmask = store_q ? wmask_c : '0;
        mem_wdata = store_q ? (wdata_q << {off, 3'b000}) : '0;
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack) begin
          rdata_d = store_q ? '0 : ext;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_rd    = resp_valid ? rd_q : '0;
  assign resp_err   = resp_valid & err_q;
endmodule
